// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32-style iomem bus between NUM_REQ masters.
// Define IOMEM_ARB_TIMEOUT_EN to build the BUSY watchdog that forces completion with 32'hDEAD_BEEF.
module iomem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_wstrb,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [31:0]             req_rdata,
  output logic                    iomem_valid,
  input  logic                    iomem_ready,
  output logic [3:0]              iomem_wstrb,
  output logic [31:0]             iomem_addr,
  output logic [31:0]             iomem_wdata,
  input  logic [31:0]             iomem_rdata,
  output logic [2:0]              grant_idx,
  output logic                    timeout_err,
  output logic                    dbg_state
);

  // Handshake: a requester holds req_valid and its payload until it sees its
  // req_ready bit for one cycle; the downstream side holds iomem_* until iomem_ready.

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("iomem_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("iomem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [3:0] NREQ4 = 4'(NUM_REQ);

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic        valid_q, valid_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [7:0]  valid_pad;
  logic [3:0]  cand;
  logic        pick_found;
  logic [2:0]  pick_idx;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_addr, sel_wdata;
  logic        force_done;
  logic        done;

  // Search starts just after the last grant, so the last winner is lowest priority.
  always_comb begin
    valid_pad  = 8'(req_valid);
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, grant_q} + 4'(k);
      if (cand >= NREQ4) cand = cand - NREQ4;
      if (!pick_found && valid_pad[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    sel_wstrb = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_wstrb = req_wstrb[4*i +: 4];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  assign done = iomem_ready | force_done;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          valid_d = 1'b1;
          grant_d = pick_idx;
          wstrb_d = sel_wstrb;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == BUSY && done) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == 3'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  assign req_rdata = force_done ? 32'hDEAD_BEEF : iomem_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 3'(NUM_REQ - 1);
      valid_q <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          terr_q, terr_d;

  // A late iomem_ready in the final allowed cycle still wins over the watchdog.
  assign force_done = (state_q == BUSY) && !iomem_ready &&
                      (tcnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    terr_d = terr_q;
    if (state_q == IDLE)   tcnt_d = '0;
    else if (!iomem_ready) tcnt_d = tcnt_q + CW'(1);
    if (force_done)        terr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign force_done  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign iomem_valid = valid_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign grant_idx   = grant_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter with three requesters and a 16-cycle watchdog limit.
module tb_iomem_arbiter;

  localparam int NR = 3;

  logic           clk = 1'b0;
  logic           resetn;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [4*NR-1:0]  req_wstrb;
  logic [32*NR-1:0] req_addr;
  logic [32*NR-1:0] req_wdata;
  logic [31:0]    req_rdata;
  logic           iomem_valid;
  logic           iomem_ready;
  logic [3:0]     iomem_wstrb;
  logic [31:0]    iomem_addr;
  logic [31:0]    iomem_wdata;
  logic [31:0]    iomem_rdata;
  logic [2:0]     grant_idx;
  logic           timeout_err;
  logic           dbg_state;

  int n_vec = 0;
  int n_err = 0;

  iomem_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wstrb(req_wstrb),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .grant_idx(grant_idx), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    req_wstrb[4*i +: 4]  = s;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  initial begin
    resetn = 1'b0; req_valid = '0; req_wstrb = '0; req_addr = '0; req_wdata = '0;
    iomem_ready = 1'b0; iomem_rdata = '0;
    tick(); tick(); settle();
    chk("rst_valid", 32'(iomem_valid), 32'd0);
    chk("rst_addr", iomem_addr, 32'd0);
    chk("rst_wstrb", 32'(iomem_wstrb), 32'd0);
    chk("rst_wdata", iomem_wdata, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd2);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Single read from requester 0, peripheral answers in the third BUSY cycle
    resetn = 1'b1;
    set_req(0, 4'h0, 32'h0300_0010, 32'h0);
    req_valid = 3'b001; settle();
    chk("rd_pre_valid", 32'(iomem_valid), 32'd0);
    tick(); settle();
    chk("rd_valid", 32'(iomem_valid), 32'd1);
    chk("rd_addr", iomem_addr, 32'h0300_0010);
    chk("rd_wstrb", 32'(iomem_wstrb), 32'd0);
    chk("rd_grant", 32'(grant_idx), 32'd0);
    chk("rd_ready_c1", 32'(req_ready), 32'd0);
    tick(); settle();
    chk("rd_ready_c2", 32'(req_ready), 32'd0);
    tick(); iomem_ready = 1'b1; iomem_rdata = 32'h1234_5678; settle();
    chk("rd_ready_c3", 32'(req_ready), 32'b001);
    chk("rd_rdata", req_rdata, 32'h1234_5678);
    tick(); iomem_ready = 1'b0; req_valid = '0; settle();
    chk("rd_done_valid", 32'(iomem_valid), 32'd0);
    chk("rd_done_ready", 32'(req_ready), 32'd0);
    iomem_ready = 1'b1; settle();
    chk("idle_ready_ign", 32'(req_ready), 32'd0);
    tick(); iomem_ready = 1'b0; settle();
    chk("idle_state", 32'(dbg_state), 32'd0);

    // Write from requester 1; payload must stay on iomem_* while others change
    set_req(1, 4'b0011, 32'h0400_0000, 32'hCAFE_F00D);
    req_valid = 3'b010;
    tick(); settle();
    chk("wr_grant", 32'(grant_idx), 32'd1);
    chk("wr_valid", 32'(iomem_valid), 32'd1);
    chk("wr_addr", iomem_addr, 32'h0400_0000);
    chk("wr_wdata", iomem_wdata, 32'hCAFE_F00D);
    chk("wr_wstrb", 32'(iomem_wstrb), 32'b0011);
    set_req(0, 4'hF, 32'h1111_1111, 32'h2222_2222);
    req_valid = 3'b011;
    tick(); settle();
    chk("wr_hold_addr", iomem_addr, 32'h0400_0000);
    chk("wr_hold_wdata", iomem_wdata, 32'hCAFE_F00D);
    chk("wr_hold_wstrb", 32'(iomem_wstrb), 32'b0011);
    chk("wr_wait_ready", 32'(req_ready), 32'd0);
    tick(); iomem_ready = 1'b1; settle();
    chk("wr_ready", 32'(req_ready), 32'b010);

    // Requester 0 granted, drops valid mid-BUSY; transfer still completes
    tick(); iomem_ready = 1'b0; req_valid = 3'b001;
    set_req(0, 4'h0, 32'h0300_0020, 32'h0); settle();
    tick(); settle();
    chk("ab_grant", 32'(grant_idx), 32'd0);
    chk("ab_addr", iomem_addr, 32'h0300_0020);
    req_valid = '0;
    tick(); settle();
    chk("ab_hold_valid", 32'(iomem_valid), 32'd1);
    chk("ab_state", 32'(dbg_state), 32'd1);
    tick(); iomem_ready = 1'b1; iomem_rdata = 32'h0BAD_F00D; settle();
    chk("ab_ready", 32'(req_ready), 32'b001);
    chk("ab_rdata", req_rdata, 32'h0BAD_F00D);
    tick(); iomem_ready = 1'b0; settle();
    chk("ab_done_valid", 32'(iomem_valid), 32'd0);

    // Reset while BUSY abandons the access
    set_req(1, 4'hF, 32'h0400_0004, 32'h55AA_55AA);
    req_valid = 3'b010;
    tick(); settle();
    chk("rs_busy", 32'(dbg_state), 32'd1);
    chk("rs_grant1", 32'(grant_idx), 32'd1);
    resetn = 1'b0;
    tick(); settle();
    chk("rs_valid", 32'(iomem_valid), 32'd0);
    chk("rs_state", 32'(dbg_state), 32'd0);
    chk("rs_grant", 32'(grant_idx), 32'd2);
    chk("rs_addr", iomem_addr, 32'd0);
    chk("rs_ready", 32'(req_ready), 32'd0);

    // Round robin: all valid, 1-cycle peripheral, each winner drops for one cycle
    resetn = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 4'h0, 32'h0300_0100 + 32'(4*i), 32'h0);
    req_valid = 3'b111; iomem_ready = 1'b1; iomem_rdata = 32'h0000_0042;
    for (int k = 0; k < 6; k++) begin
      tick(); req_valid = 3'b111; settle();
      chk($sformatf("rr%0d_grant", k), 32'(grant_idx), 32'(k % NR));
      chk($sformatf("rr%0d_valid", k), 32'(iomem_valid), 32'd1);
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << (k % NR)));
      chk($sformatf("rr%0d_addr", k), iomem_addr, 32'h0300_0100 + 32'(4*(k % NR)));
      tick(); req_valid = 3'b111 & ~3'(1 << (k % NR)); settle();
      chk($sformatf("rr%0d_idle_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("rr%0d_idle_valid", k), 32'(iomem_valid), 32'd0);
    end
    req_valid = '0; iomem_ready = 1'b0;
    tick(); settle();

`ifdef IOMEM_ARB_TIMEOUT_EN
    // Boundary: iomem_ready in the 16th BUSY cycle completes normally
    set_req(1, 4'h0, 32'h0300_0040, 32'h0);
    req_valid = 3'b010;
    tick(); settle();
    chk("tb_grant", 32'(grant_idx), 32'd1);
    for (int c = 1; c < 16; c++) begin
      chk($sformatf("tb_wait%0d", c), 32'(req_ready), 32'd0);
      tick(); settle();
    end
    iomem_ready = 1'b1; iomem_rdata = 32'h600D_D47A; settle();
    chk("tb_ready", 32'(req_ready), 32'b010);
    chk("tb_rdata", req_rdata, 32'h600D_D47A);
    tick(); iomem_ready = 1'b0; req_valid = '0; settle();
    chk("tb_terr", 32'(timeout_err), 32'd0);
    chk("tb_state", 32'(dbg_state), 32'd0);

    // Timeout: no iomem_ready, forced completion in the 16th BUSY cycle
    set_req(0, 4'h0, 32'h0300_0030, 32'h0);
    req_valid = 3'b001;
    tick(); settle();
    chk("to_grant", 32'(grant_idx), 32'd0);
    for (int c = 1; c < 16; c++) begin
      chk($sformatf("to_wait%0d", c), 32'(req_ready), 32'd0);
      tick(); settle();
    end
    chk("to_ready", 32'(req_ready), 32'b001);
    chk("to_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("to_terr_pre", 32'(timeout_err), 32'd0);
    tick(); req_valid = '0; settle();
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_valid", 32'(iomem_valid), 32'd0);
    chk("to_state", 32'(dbg_state), 32'd0);
    tick(); tick(); tick(); settle();
    chk("to_sticky", 32'(timeout_err), 32'd1);
`else
    // Without the watchdog a long stall simply waits for the peripheral
    set_req(0, 4'h0, 32'h0300_0030, 32'h0);
    req_valid = 3'b001;
    tick(); settle();
    chk("st_grant", 32'(grant_idx), 32'd0);
    for (int c = 1; c < 20; c++) begin
      chk($sformatf("st_wait%0d", c), 32'(req_ready), 32'd0);
      tick(); settle();
    end
    chk("st_valid", 32'(iomem_valid), 32'd1);
    chk("st_terr", 32'(timeout_err), 32'd0);
    iomem_ready = 1'b1; iomem_rdata = 32'h7777_1234; settle();
    chk("st_ready", 32'(req_ready), 32'b001);
    chk("st_rdata", req_rdata, 32'h7777_1234);
    tick(); iomem_ready = 1'b0; req_valid = '0; settle();
    chk("st_terr_after", 32'(timeout_err), 32'd0);
    chk("st_state", 32'(dbg_state), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
